// File: rtl/regfile_wq_pkg.sv
// Shared types and constants for the regfile write queue.
package regfile_wq_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wq_entry_t;

endpackage

// File: rtl/regfile_wq_match.sv
// Combinational pending-write lookup: returns the youngest stored entry matching look_raddr.
module regfile_wq_match
    import regfile_wq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wq_entry_t                  entries [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [4:0]                 look_raddr,
    output logic                       hit,
    output logic [31:0]                data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = 32'd0;
        idx  = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].waddr == look_raddr) && (look_raddr != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[idx].wdata;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Circular buffer of pending regfile writes driving the single write port, with bypass lookup.
module regfile_write_queue
    import regfile_wq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [4:0]                 enq_waddr,
    input  logic [31:0]                enq_wdata,
    input  logic                       drain_en,
    output logic                       wen,
    output logic [4:0]                 waddr,
    output logic [31:0]                wdata,
    input  logic [4:0]                 look_raddr,
    output logic                       look_hit,
    output logic [31:0]                look_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wq_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] offset;
    logic             do_enq, do_store, do_deq;

    // Handshake and issue; enq_rdy depends only on stored state, so no pass-through when full.
    always_comb begin
        enq_rdy  = (count_q != FULL);
        do_enq   = enq_val && enq_rdy;
        do_store = do_enq && (enq_waddr != REG_ZERO);
        do_deq   = drain_en && (count_q != '0);
        wen      = do_deq;
        waddr    = 5'd0;
        wdata    = 32'd0;
        if (count_q != '0) begin
            waddr = mem_q[head_q].waddr;
            wdata = mem_q[head_q].wdata;
        end
    end

    always_comb begin
        head_d  = do_deq   ? head_q + PTR_W'(1) : head_q;
        tail_d  = do_store ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        unique case ({do_store, do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            offset   = PTR_W'(j) - head_q;
            valid[j] = ({1'b0, offset} < count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_q[tail_q] <= '{waddr: enq_waddr, wdata: enq_wdata};
        end
    end

    regfile_wq_match #(
        .DEPTH(DEPTH)
    ) u_match (
        .entries    (mem_q),
        .valid      (valid),
        .head       (head_q),
        .look_raddr (look_raddr),
        .hit        (look_hit),
        .data       (look_data)
    );

    assign count = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue (DEPTH=4).
module tb_regfile_write_queue;

    logic        clk;
    logic        rst_n;
    logic        enq_val;
    logic        enq_rdy;
    logic [4:0]  enq_waddr;
    logic [31:0] enq_wdata;
    logic        drain_en;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  look_raddr;
    logic        look_hit;
    logic [31:0] look_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_queue #(
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq_val    (enq_val),
        .enq_rdy    (enq_rdy),
        .enq_waddr  (enq_waddr),
        .enq_wdata  (enq_wdata),
        .drain_en   (drain_en),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .look_raddr (look_raddr),
        .look_hit   (look_hit),
        .look_data  (look_data),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_all_hits(output int hits);
        hits = 0;
        for (int r = 0; r < 32; r++) begin
            look_raddr = 5'(r);
            #1;
            if (look_hit) hits++;
        end
    endtask

    initial begin
        int hits;
        rst_n      = 1'b0;
        enq_val    = 1'b0;
        enq_waddr  = 5'd0;
        enq_wdata  = 32'd0;
        drain_en   = 1'b0;
        look_raddr = 5'd0;

        // Reset and idle
        step();
        step();
        check("rst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        count_all_hits(hits);
        check("rst_look_hits", 32'(hits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_enq_rdy", 32'(enq_rdy), 32'd1);
        check("idle_count", 32'(count), 32'd0);
        count_all_hits(hits);
        check("idle_look_hits", 32'(hits), 32'd0);
        check("idle_look_data", look_data, 32'd0);

        // Single write
        enq_val    = 1'b1;
        enq_waddr  = 5'd5;
        enq_wdata  = 32'hDEADBEEF;
        drain_en   = 1'b1;
        look_raddr = 5'd5;
        #1;
        check("single_rdy", 32'(enq_rdy), 32'd1);
        check("single_incoming_not_searched", 32'(look_hit), 32'd0);
        step();
        enq_val = 1'b0;
        #1;
        check("single_wen", 32'(wen), 32'd1);
        check("single_waddr", 32'(waddr), 32'd5);
        check("single_wdata", wdata, 32'hDEADBEEF);
        check("single_look_hit", 32'(look_hit), 32'd1);
        check("single_look_data", look_data, 32'hDEADBEEF);
        check("single_count", 32'(count), 32'd1);
        step();
        check("single_after_count", 32'(count), 32'd0);
        check("single_after_wen", 32'(wen), 32'd0);
        check("single_after_hit", 32'(look_hit), 32'd0);

        // Full / backpressure
        drain_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            enq_val   = 1'b1;
            enq_waddr = 5'(k);
            enq_wdata = 32'h100 + 32'(k);
            #1;
            check($sformatf("fill_rdy_%0d", k), 32'(enq_rdy), 32'd1);
            step();
        end
        enq_waddr = 5'd5;
        enq_wdata = 32'h105;
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_rdy", 32'(enq_rdy), 32'd0);
        check("full_no_wen", 32'(wen), 32'd0);
        step();
        check("full_held_count", 32'(count), 32'd4);
        check("full_held_rdy", 32'(enq_rdy), 32'd0);
        drain_en = 1'b1;
        #1;
        check("full_no_passthru", 32'(enq_rdy), 32'd0);
        for (int j = 1; j <= 5; j++) begin
            check($sformatf("drain_wen_%0d", j), 32'(wen), 32'd1);
            check($sformatf("drain_waddr_%0d", j), 32'(waddr), 32'(j));
            check($sformatf("drain_wdata_%0d", j), wdata, 32'h100 + 32'(j));
            if (j == 2) check("drain_x5_rdy", 32'(enq_rdy), 32'd1);
            step();
            if (j == 2) enq_val = 1'b0;
        end
        check("drain_done_count", 32'(count), 32'd0);
        check("drain_done_wen", 32'(wen), 32'd0);

        // x0 drop
        enq_val    = 1'b1;
        enq_waddr  = 5'd0;
        enq_wdata  = 32'h1234;
        look_raddr = 5'd0;
        #1;
        check("x0_rdy", 32'(enq_rdy), 32'd1);
        step();
        enq_val = 1'b0;
        #1;
        check("x0_count", 32'(count), 32'd0);
        check("x0_wen", 32'(wen), 32'd0);
        check("x0_look_hit", 32'(look_hit), 32'd0);
        step();
        check("x0_wen_later", 32'(wen), 32'd0);

        // Youngest match
        drain_en   = 1'b0;
        enq_val    = 1'b1;
        enq_waddr  = 5'd7;
        enq_wdata  = 32'h11;
        step();
        enq_wdata  = 32'h22;
        step();
        enq_val    = 1'b0;
        look_raddr = 5'd7;
        #1;
        check("young_count", 32'(count), 32'd2);
        check("young_hit", 32'(look_hit), 32'd1);
        check("young_data", look_data, 32'h22);
        drain_en = 1'b1;
        #1;
        check("young_issue1_wdata", wdata, 32'h11);
        step();
        check("young_after1_hit", 32'(look_hit), 32'd1);
        check("young_after1_data", look_data, 32'h22);
        check("young_after1_wdata", wdata, 32'h22);
        step();
        check("young_after2_hit", 32'(look_hit), 32'd0);
        check("young_after2_data", look_data, 32'd0);
        check("young_after2_count", 32'(count), 32'd0);

        // Simultaneous enqueue/dequeue across pointer wrap, then reset mid-stream
        enq_val   = 1'b1;
        enq_waddr = 5'd10;
        enq_wdata = 32'hA000;
        step();
        for (int k = 1; k <= 10; k++) begin
            look_raddr = 5'(k + 9);
            #1;
            check($sformatf("stream_count_%0d", k), 32'(count), 32'd1);
            check($sformatf("stream_wen_%0d", k), 32'(wen), 32'd1);
            check($sformatf("stream_waddr_%0d", k), 32'(waddr), 32'(k + 9));
            check($sformatf("stream_wdata_%0d", k), wdata, 32'hA000 + 32'(k - 1));
            check($sformatf("stream_look_%0d", k), look_data, 32'hA000 + 32'(k - 1));
            enq_waddr = 5'(k + 10);
            enq_wdata = 32'hA000 + 32'(k);
            step();
        end
        look_raddr = 5'd20;
        #1;
        check("pre_rst_count", 32'(count), 32'd1);
        check("pre_rst_hit", 32'(look_hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_wen", 32'(wen), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_hit", 32'(look_hit), 32'd0);
        check("midrst_rdy", 32'(enq_rdy), 32'd1);
        enq_val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_wen", 32'(wen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
